// File: rtl/sar_search.sv
// sar_search: successive-approximation search engine.
// Resolves an unknown WIDTH-bit value one bit per probe, MSB first, by driving
// trial operands to an external magnitude comparator and consuming its
// less-than flag. Reports the recovered value with a one-cycle done pulse.
//
// Build option: define SAR_SEARCH_TIMEOUT_EN to abort a search when the
// comparator stays silent for TIMEOUT cycles on one probe (err=1, partial
// result). Without it the engine waits indefinitely and err is tied low.
module sar_search #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  output logic             probe_valid,
  input  logic             cmp_valid,
  input  logic             cmp_less,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [KW-1:0]    K_ONE = KW'(1);
  localparam logic [KW-1:0]    K_MSB = KW'(WIDTH - 1);

  // Reject configurations the bit index or wait counter cannot represent.
  if (WIDTH < 2 || WIDTH > 16 || TIMEOUT < 1) begin : g_bad_param
    $error("sar_search: WIDTH must be 2..16 and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic             probe_valid_q, probe_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

`ifdef SAR_SEARCH_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // Bit under test and the accumulator after applying the comparator verdict.
  logic [WIDTH-1:0] bit_s;
  logic [WIDTH-1:0] acc_upd_s;
  logic             accept_s;

  // Decode the current probe bit and fold the response into the accumulator.
  always_comb begin
    bit_s    = ONE_W << k_q;
    accept_s = cmp_valid & probe_valid_q;
    if (cmp_less) begin
      acc_upd_s = acc_q & ~bit_s;
    end else begin
      acc_upd_s = acc_q | bit_s;
    end
  end

  // Next-state and next-output logic; every output is computed here and then
  // registered, so nothing from cmp_valid/cmp_less reaches a port directly.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    k_d           = k_q;
    probe_d       = probe_q;
    probe_valid_d = probe_valid_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    result_d      = result_q;
    err_d         = err_q;
`ifdef SAR_SEARCH_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_PROBE;
          acc_d         = {WIDTH{1'b0}};
          k_d           = K_MSB;
          err_d         = 1'b0;
          probe_d       = ONE_W << K_MSB;
          probe_valid_d = 1'b1;
          busy_d        = 1'b1;
`ifdef SAR_SEARCH_TIMEOUT_EN
          wait_cnt_d    = {WCW{1'b0}};
`endif
        end else begin
          probe_valid_d = 1'b0;
          busy_d        = 1'b0;
        end
      end

      ST_PROBE: begin
        if (accept_s) begin
          acc_d = acc_upd_s;
          if (k_q == {KW{1'b0}}) begin
            // Last bit resolved: publish the result alongside the done pulse.
            state_d       = ST_DONE;
            probe_d       = {WIDTH{1'b0}};
            probe_valid_d = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            result_d      = acc_upd_s;
          end else begin
            k_d     = k_q - K_ONE;
            probe_d = acc_upd_s | (ONE_W << (k_q - K_ONE));
`ifdef SAR_SEARCH_TIMEOUT_EN
            wait_cnt_d = {WCW{1'b0}};
`endif
          end
        end else begin
`ifdef SAR_SEARCH_TIMEOUT_EN
          if (wait_cnt_q == WAIT_LAST) begin
            // Comparator went silent: abort with the bits resolved so far.
            state_d       = ST_DONE;
            probe_d       = {WIDTH{1'b0}};
            probe_valid_d = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            result_d      = acc_q;
            err_d         = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
          end
`else
          state_d = ST_PROBE;
`endif
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d       = ST_IDLE;
        probe_d       = {WIDTH{1'b0}};
        probe_valid_d = 1'b0;
        busy_d        = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      acc_q         <= {WIDTH{1'b0}};
      k_q           <= K_MSB;
      probe_q       <= {WIDTH{1'b0}};
      probe_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= {WIDTH{1'b0}};
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      k_q           <= k_d;
      probe_q       <= probe_d;
      probe_valid_q <= probe_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      result_q      <= result_d;
      err_q         <= err_d;
    end
  end

`ifdef SAR_SEARCH_TIMEOUT_EN
  // Per-probe wait counter, restarted whenever a new probe is issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= {WCW{1'b0}};
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  assign probe       = probe_q;
  assign probe_valid = probe_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
`ifdef SAR_SEARCH_TIMEOUT_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: a behavioural comparator responder with
// configurable wait states, checked against a plain binary-search model.
module tb_sar_search;

  localparam int W  = 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] probe;
  logic         probe_valid;
  logic         cmp_valid;
  logic         cmp_less;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] last_res;

  sar_search #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .probe       (probe),
    .probe_valid (probe_valid),
    .cmp_valid   (cmp_valid),
    .cmp_less    (cmp_less),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Binary search over [0, 2^W): lower bound after n answered probes.
  function automatic int ref_lo(input logic [W-1:0] secret, input int n);
    int lo;
    int step;
    lo   = 0;
    step = 1 << (W - 1);
    for (int j = 0; j < n; j++) begin
      if (int'(secret) >= lo + step) lo = lo + step;
      step = step / 2;
    end
    return lo;
  endfunction

  // Trial operand expected as the (i+1)-th probe of a search for secret.
  function automatic logic [W-1:0] ref_probe(input logic [W-1:0] secret, input int i);
    return W'(ref_lo(secret, i) + (1 << (W - 1 - i)));
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_probe"}, 32'(probe), 32'd0);
    check({tag, "_pvalid"}, 32'(probe_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // One search with a responder that waits d cycles per probe. stray_cyc>0
  // pulses start during that cycle; silent_after>0 stops answering after that
  // many probes.
  task automatic run_search(input logic [W-1:0] secret, input int d,
                            input int stray_cyc, input int silent_after);
    int           cyc;
    int           wcnt;
    int           np;
    int           done_cyc;
    int           exp_done;
    bit           fin;
    bit           timed;
    bit           expect_to;
    logic [W-1:0] held;
    logic [W-1:0] exp_res;
    timed = (silent_after > 0);
`ifdef SAR_SEARCH_TIMEOUT_EN
    expect_to = 1'b1;
`else
    expect_to = 1'b0;
`endif
    exp_done = timed ? (1 + silent_after * (d + 1) + TO) : (1 + W * (d + 1));
    exp_res  = timed ? W'(ref_lo(secret, silent_after)) : secret;
    held     = '0;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    cyc      = 1;
    wcnt     = 0;
    np       = 0;
    fin      = 1'b0;
    done_cyc = 0;
    while (!fin && cyc < 200) begin
      cmp_valid = 1'b0;
      cmp_less  = 1'($urandom_range(0, 1));
      start     = (cyc + 1 == stray_cyc);
      if (cyc == 1) begin
        check("err_cleared_on_start", 32'(err), 32'd0);
        check("result_kept_until_done", 32'(result), 32'(last_res));
      end
      if (done) begin
        fin      = 1'b1;
        done_cyc = cyc;
      end else if (probe_valid) begin
        check("busy_during_probe", 32'(busy), 32'd1);
        if (wcnt == 0) begin
          check("probe_value", 32'(probe), 32'(ref_probe(secret, np)));
          held = probe;
        end else begin
          check("probe_stable", 32'(probe), 32'(held));
        end
        if (!(timed && np >= silent_after) && wcnt == d) begin
          cmp_valid = 1'b1;
          cmp_less  = (secret < probe);
          np++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        check("probe_valid_in_search", 32'(probe_valid), 32'd1);
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    cmp_valid = 1'b0;
    start     = 1'b0;
    if (timed && !expect_to) begin
      check("no_timeout_no_done", 32'(fin), 32'd0);
      check("no_timeout_still_busy", 32'(busy), 32'd1);
    end else begin
      check("done_seen", 32'(fin), 32'd1);
      check("done_cycle", 32'(done_cyc), 32'(exp_done));
      check("result", 32'(result), 32'(exp_res));
      check("err_at_done", 32'(err), 32'(timed));
      check("probe_valid_at_done", 32'(probe_valid), 32'd0);
      @(negedge clk);
      check("done_single_pulse", 32'(done), 32'd0);
      check("result_held", 32'(result), 32'(exp_res));
      check("err_held", 32'(err), 32'(timed));
      last_res = exp_res;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    cmp_valid = 1'b0;
    cmp_less  = 1'b0;
    last_res  = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Stray comparator responses while idle must be ignored.
    cmp_valid = 1'b1;
    cmp_less  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_stray_pvalid", 32'(probe_valid), 32'd0);
      check("idle_stray_done", 32'(done), 32'd0);
    end
    cmp_valid = 1'b0;
    cmp_less  = 1'b0;

    run_search(8'h00, 0, 0, 0);
    run_search(8'hFF, 0, 0, 0);
    run_search(8'hA5, 3, 0, 0);
    run_search(8'h3C, 0, 4, 0);

    // Reset in cycle 5 of a 0x5A search, with a response arriving afterwards.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 5; c++) begin
      cmp_valid = probe_valid;
      cmp_less  = (8'h5A < probe);
      @(negedge clk);
    end
    reset_n   = 1'b0;
    cmp_valid = 1'b1;
    cmp_less  = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_resp_ignored_pv", 32'(probe_valid), 32'd0);
    check("post_reset_resp_ignored_done", 32'(done), 32'd0);
    cmp_valid = 1'b0;
    last_res  = '0;
    run_search(8'h5A, 0, 0, 0);

    // Comparator goes silent after the third probe.
    run_search(8'hE0, 0, 0, 3);
`ifndef SAR_SEARCH_TIMEOUT_EN
    reset_n = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    last_res = '0;
    @(negedge clk);
`endif

    for (int r = 0; r < 6; r++) begin
      run_search(W'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 10)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search engine that recovers an unknown WIDTH-bit value by issuing trial operands to an external magnitude comparator and consuming its less-than flag. It is the initiator side of the ALU comparator path: it produces operand probes and reads back one comparison result per probe. It resolves one bit per probe, MSB first, and reports the recovered value with a done pulse.

## Interface
- WIDTH, 8, operand width and number of probes per search (2..16)
- TIMEOUT, 16, cycles to wait for a comparator response before aborting (used only with SAR_SEARCH_TIMEOUT_EN)
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  begin a search; sampled only in IDLE
- probe  output  WIDTH  trial operand driven to comparator input b (comparator input a carries the secret value)
- probe_valid  output  1  probe is valid and awaiting a response
- cmp_valid  input  1  comparator response valid; accepted only while probe_valid=1
- cmp_less  input  1  response flag: 1 means secret < probe
- busy  output  1  high in PROBE state
- done  output  1  one-cycle pulse when result is final
- result  output  WIDTH  recovered value; held until next start
- err  output  1  timeout flag (constant 0 when timeout is compiled out)

## Operation
- States: IDLE, PROBE, DONE.
- IDLE: start=1 -> PROBE; acc cleared to 0, bit index k=WIDTH-1, err cleared; result keeps its old value until DONE.
- PROBE: probe = acc | (1<<k); probe_valid=1. On cycle with cmp_valid=1: if cmp_less=0 set acc[k]=1, else acc[k]=0. If k=0 -> DONE, else k decrements and the next probe is driven the following cycle.
- DONE: result <= final acc, done=1 for one cycle, -> IDLE.
- Arithmetic: probe and acc are unsigned WIDTH-bit; no carries; probe never exceeds 2^WIDTH-1.
- cmp_valid while probe_valid=0 is ignored. start while busy or in DONE is ignored.
- cmp_valid and start in the same cycle in PROBE: response accepted, start ignored.
- Reset (any state, including mid-search): state=IDLE, probe=0, probe_valid=0, busy=0, done=0, result=0, err=0, acc=0, k=WIDTH-1. A response arriving after reset is ignored.

## Timing
- start sampled at edge 0; first probe valid in cycle 1.
- Zero-wait responder (cmp_valid same cycle as probe_valid): probes in cycles 1..WIDTH, probe_valid continuously high, done in cycle WIDTH+1; start accepted again in cycle WIDTH+2.
- Responder with d wait cycles per probe: done at cycle 1+WIDTH*(d+1).
- probe is stable while probe_valid=1 and not yet acknowledged; changes only in the cycle after acceptance.
- All outputs are registered; no combinational path from cmp_valid/cmp_less to any output.

## Configuration
- SAR_SEARCH_TIMEOUT_EN defined: a wait counter resets on every new probe; if TIMEOUT cycles elapse in PROBE without cmp_valid, the engine goes to DONE with err=1, result=partial acc (unresolved bits 0), done pulses. err holds until the next accepted start or reset.
- Not defined: engine waits indefinitely for cmp_valid; err tied to 0; no counter logic.

## Test plan
- WIDTH=8, secret 0x00, zero-wait responder -> probes 0x80,0x40,0x20,0x10,0x08,0x04,0x02,0x01; result 0x00; done at cycle 9.
- Secret 0xFF, zero-wait -> probes 0x80,0xC0,0xE0,...,0xFF; result 0xFF; err 0.
- Secret 0xA5, responder 3-cycle wait per probe -> probe held stable during waits; result 0xA5; done at cycle 33.
- start pulsed in cycle 4 of a search, and stray cmp_valid while idle -> no effect; single done; result correct.
- reset_n low in cycle 5 of a 0x5A search -> all outputs 0 immediately; new start then returns 0x5A.
- With SAR_SEARCH_TIMEOUT_EN, TIMEOUT=16: responder silent after 3rd probe for secret 0xE0 -> done with err=1, result 0xE0 (bits 7..5 resolved); without macro, engine stays busy.
